// File: rtl/mult_div_if.sv
// Request/result bundle between a pipeline and the HI/LO multiply-divide unit.
interface mult_div_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] srcA;
  logic [31:0] srcB;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output start, op, srcA, srcB,
    input  busy, HI, LO
  );

  modport slave (
    input  start, op, srcA, srcB,
    output busy, HI, LO
  );
endinterface

// File: rtl/mult_div_unit.sv
// MIPS-style HI/LO multiply/divide unit with fixed busy latency per op class.
// Results are computed at acceptance and held in shadow registers until commit.
module mult_div_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  mult_div_if.slave  bus
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  localparam logic [2:0] OpMult  = 3'b000;
  localparam logic [2:0] OpMultu = 3'b001;
  localparam logic [2:0] OpDiv   = 3'b010;
  localparam logic [2:0] OpDivu  = 3'b011;
  localparam logic [2:0] OpMthi  = 3'b100;
  localparam logic [2:0] OpMtlo  = 3'b101;

  state_e      state_q;
  logic        busy_q;
  logic [31:0] cnt_q;
  logic [31:0] hi_q, lo_q;
  logic [31:0] hi_n_q, lo_n_q;

  logic [63:0] a_sx, b_sx, prod_s, prod_u;
  logic [31:0] a_mag, b_mag, b_mag_safe, q_mag, r_mag, sq, sr;
  logic [31:0] b_safe, uq, ur;

  always_comb begin
    a_sx   = {{32{bus.srcA[31]}}, bus.srcA};
    b_sx   = {{32{bus.srcB[31]}}, bus.srcB};
    // Low 64 bits of a sign-extended product equal the signed 32x32 product.
    prod_s = a_sx * b_sx;
    prod_u = {32'd0, bus.srcA} * {32'd0, bus.srcB};

    // Signed divide via magnitudes; INT_MIN / -1 wraps naturally to INT_MIN, remainder 0.
    a_mag      = bus.srcA[31] ? (~bus.srcA + 32'd1) : bus.srcA;
    b_mag      = bus.srcB[31] ? (~bus.srcB + 32'd1) : bus.srcB;
    b_mag_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
    q_mag      = a_mag / b_mag_safe;
    r_mag      = a_mag % b_mag_safe;
    sq         = (bus.srcA[31] ^ bus.srcB[31]) ? (~q_mag + 32'd1) : q_mag;
    sr         = bus.srcA[31] ? (~r_mag + 32'd1) : r_mag;

    b_safe = (bus.srcB == 32'd0) ? 32'd1 : bus.srcB;
    uq     = bus.srcA / b_safe;
    ur     = bus.srcA % b_safe;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      busy_q  <= 1'b0;
      cnt_q   <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      hi_n_q  <= 32'd0;
      lo_n_q  <= 32'd0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.start) begin
            case (bus.op)
              OpMult, OpMultu: begin
                hi_n_q  <= (bus.op == OpMult) ? prod_s[63:32] : prod_u[63:32];
                lo_n_q  <= (bus.op == OpMult) ? prod_s[31:0]  : prod_u[31:0];
                cnt_q   <= 32'(MULT_CYCLES);
                state_q <= StBusy;
                busy_q  <= 1'b1;
              end
              OpDiv, OpDivu: begin
                // Divide by zero commits the current HI/LO back, leaving them unchanged.
                if (bus.srcB == 32'd0) begin
                  hi_n_q <= hi_q;
                  lo_n_q <= lo_q;
                end else begin
                  hi_n_q <= (bus.op == OpDiv) ? sr : ur;
                  lo_n_q <= (bus.op == OpDiv) ? sq : uq;
                end
                cnt_q   <= 32'(DIV_CYCLES);
                state_q <= StBusy;
                busy_q  <= 1'b1;
              end
              OpMthi:  hi_q <= bus.srcA;
              OpMtlo:  lo_q <= bus.srcA;
              default: ;
            endcase
          end
        end
        StBusy: begin
          if (cnt_q <= 32'd1) begin
            cnt_q   <= 32'd0;
            hi_q    <= hi_n_q;
            lo_q    <= lo_n_q;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q - 32'd1;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: per-cycle compare against an arithmetic model plus
// hand-computed result and latency checks.
module tb_mult_div_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;

  mult_div_if bus ();

  mult_div_unit #(
    .MULT_CYCLES(MC),
    .DIV_CYCLES (DC)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
  endtask

  // Reference arithmetic on 64-bit integers; returns {hi, lo}.
  function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] a,
                                             input logic [31:0] b);
    longint x, y, q, r;
    logic [63:0] p;
    case (o)
      3'b000: begin
        x = longint'($signed(a));
        y = longint'($signed(b));
        p = 64'(x * y);
      end
      3'b001: p = 64'(a) * 64'(b);
      3'b010: begin
        x = longint'($signed(a));
        y = longint'($signed(b));
        q = x / y;
        r = x % y;
        p = {r[31:0], q[31:0]};
      end
      default: begin
        x = longint'(a);
        y = longint'(b);
        q = x / y;
        r = x % y;
        p = {r[31:0], q[31:0]};
      end
    endcase
    return p;
  endfunction

  // Model: remaining busy cycles and the pending result (if any) to land when it expires.
  logic        m_busy;
  int          m_left;
  logic [31:0] m_hi, m_lo, m_phi, m_plo;
  logic        m_commit;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_busy   <= 1'b0;
      m_left   <= 0;
      m_hi     <= 32'd0;
      m_lo     <= 32'd0;
      m_phi    <= 32'd0;
      m_plo    <= 32'd0;
      m_commit <= 1'b0;
    end else if (m_busy) begin
      if (m_left == 1) begin
        m_busy <= 1'b0;
        m_left <= 0;
        if (m_commit) begin
          m_hi <= m_phi;
          m_lo <= m_plo;
        end
      end else begin
        m_left <= m_left - 1;
      end
    end else if (bus.start) begin
      case (bus.op)
        3'b000, 3'b001: begin
          {m_phi, m_plo} <= ref_result(bus.op, bus.srcA, bus.srcB);
          m_commit <= 1'b1;
          m_busy   <= 1'b1;
          m_left   <= MC;
        end
        3'b010, 3'b011: begin
          if (bus.srcB != 32'd0) {m_phi, m_plo} <= ref_result(bus.op, bus.srcA, bus.srcB);
          m_commit <= (bus.srcB != 32'd0);
          m_busy   <= 1'b1;
          m_left   <= DC;
        end
        3'b100:  m_hi <= bus.srcA;
        3'b101:  m_lo <= bus.srcA;
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    check("cyc_busy", {31'd0, bus.busy}, {31'd0, m_busy});
    check("cyc_hi", bus.HI, m_hi);
    check("cyc_lo", bus.LO, m_lo);
  end

  // Called at a negedge: issue one op, then count cycles with busy high (bounded).
  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int exp_cycles);
    int cycles;
    bus.start = 1'b1;
    bus.op    = o;
    bus.srcA  = a;
    bus.srcB  = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.srcA  = $urandom;
    bus.srcB  = $urandom;
    cycles = 0;
    while (bus.busy && cycles < 100) begin
      cycles++;
      @(negedge clk);
    end
    check({name, "_cycles"}, 32'(cycles), 32'(exp_cycles));
  endtask

  initial begin
    int cycles;
    n_checks  = 0;
    n_pass    = 0;
    reset     = 1'b0;
    bus.start = 1'b0;
    bus.op    = 3'b000;
    bus.srcA  = 32'd0;
    bus.srcB  = 32'd0;
    #1;
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_hi", bus.HI, 32'd0);
    check("rst_lo", bus.LO, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    run_op("mult", 3'b000, 32'hFFFF_FFFE, 32'd3, MC);
    check("mult_hi", bus.HI, 32'hFFFF_FFFF);
    check("mult_lo", bus.LO, 32'hFFFF_FFFA);
    run_op("multu", 3'b001, 32'hFFFF_FFFE, 32'd3, MC);
    check("multu_hi", bus.HI, 32'h0000_0002);
    check("multu_lo", bus.LO, 32'hFFFF_FFFA);
    run_op("div", 3'b010, 32'hFFFF_FFF9, 32'd2, DC);
    check("div_hi", bus.HI, 32'hFFFF_FFFF);
    check("div_lo", bus.LO, 32'hFFFF_FFFD);
    run_op("divu", 3'b011, 32'd7, 32'd2, DC);
    check("divu_hi", bus.HI, 32'd1);
    check("divu_lo", bus.LO, 32'd3);
    run_op("div_negb", 3'b010, 32'd7, 32'hFFFF_FFFE, DC);
    check("div_negb_hi", bus.HI, 32'd1);
    check("div_negb_lo", bus.LO, 32'hFFFF_FFFD);
    run_op("div_ovf", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, DC);
    check("div_ovf_hi", bus.HI, 32'h0000_0000);
    check("div_ovf_lo", bus.LO, 32'h8000_0000);

    run_op("mthi", 3'b100, 32'h11, 32'd0, 0);
    check("mthi_hi", bus.HI, 32'h11);
    run_op("mtlo", 3'b101, 32'h22, 32'd0, 0);
    check("mtlo_lo", bus.LO, 32'h22);
    run_op("divu0", 3'b011, 32'd1234, 32'd0, DC);
    check("divu0_hi", bus.HI, 32'h11);
    check("divu0_lo", bus.LO, 32'h22);
    run_op("nop6", 3'b110, 32'hDEAD_BEEF, 32'd1, 0);
    run_op("nop7", 3'b111, 32'hDEAD_BEEF, 32'd1, 0);
    check("nop_hi", bus.HI, 32'h11);
    check("nop_lo", bus.LO, 32'h22);

    // MTLO attempted while a multiply is in flight must be dropped.
    bus.start = 1'b1;
    bus.op    = 3'b000;
    bus.srcA  = 32'd6;
    bus.srcB  = 32'd7;
    @(negedge clk);
    cycles = 0;
    while (bus.busy && cycles < 100) begin
      bus.start = (cycles == 1);
      bus.op    = 3'b101;
      bus.srcA  = 32'hABCD;
      cycles++;
      @(negedge clk);
    end
    bus.start = 1'b0;
    check("mtlo_busy_cycles", 32'(cycles), 32'(MC));
    check("mtlo_busy_hi", bus.HI, 32'd0);
    check("mtlo_busy_lo", bus.LO, 32'h2A);

    // Back-to-back: second op issued in the first cycle busy reads low.
    run_op("b2b_mult", 3'b001, 32'h0001_0000, 32'h0001_0000, MC);
    check("b2b_mult_hi", bus.HI, 32'd1);
    check("b2b_mult_lo", bus.LO, 32'd0);
    run_op("b2b_div", 3'b011, 32'd100, 32'd7, DC);
    check("b2b_div_hi", bus.HI, 32'd2);
    check("b2b_div_lo", bus.LO, 32'd14);

    // Reset in the third busy cycle of a divide.
    bus.start = 1'b1;
    bus.op    = 3'b010;
    bus.srcA  = 32'd50;
    bus.srcB  = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    check("abort_hi", bus.HI, 32'd0);
    check("abort_lo", bus.LO, 32'd0);
    bus.start = 1'b1;
    bus.op    = 3'b100;
    bus.srcA  = 32'h55;
    @(negedge clk);
    @(negedge clk);
    check("rst_ignore_start", bus.HI, 32'd0);
    bus.start = 1'b0;
    reset     = 1'b1;
    repeat (DC + 2) @(negedge clk);
    check("abort_after_busy", {31'd0, bus.busy}, 32'd0);
    check("abort_after_hi", bus.HI, 32'd0);
    check("abort_after_lo", bus.LO, 32'd0);

    // Start held across reset release is taken at the first edge with reset high.
    reset     = 1'b0;
    bus.start = 1'b1;
    bus.op    = 3'b100;
    bus.srcA  = 32'h77;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("first_start_hi", bus.HI, 32'h77);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, busy duration for multiply ops.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, busy duration for divide ops.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset).
REQ-005 SHALL have port start  input  1  one-cycle request to launch op.
REQ-006 SHALL have port op  input  3  3'b000 MULT, 3'b001 MULTU, 3'b010 DIV, 3'b011 DIVU, 3'b100 MTHI, 3'b101 MTLO, others no-op.
REQ-007 SHALL have port srcA  input  32  rs value (dividend / multiplicand / MTxx data).
REQ-008 SHALL have port srcB  input  32  rt value (divisor / multiplier).
REQ-009 SHALL have port busy  output  1  operation in flight.
REQ-010 SHALL have port HI  output  32  HI register, direct register output.
REQ-011 SHALL have port LO  output  32  LO register, direct register output.

Function
REQ-012 SHALL implement two states: IDLE, BUSY; plus down-counter cnt, shadow result regs hi_n/lo_n.
REQ-013 SHALL in IDLE with start=1 and op in MULT/MULTU/DIV/DIVU, capture operands' result into hi_n/lo_n, load cnt with MULT_CYCLES or DIV_CYCLES, enter BUSY at that edge.
REQ-014 SHALL assert busy from the edge accepting start for exactly N cycles (N = MULT_CYCLES or DIV_CYCLES); busy is registered, not combinational from start.
REQ-015 SHALL decrement cnt each BUSY cycle; at the edge where cnt reaches 0, write hi_n->HI, lo_n->LO, deassert busy, return to IDLE.
REQ-016 SHALL keep HI/LO at old values throughout BUSY; new values visible the cycle busy falls.
REQ-017 SHALL ignore start (any op, incl. MTHI/MTLO) while busy=1; no state change.
REQ-018 SHALL, in IDLE with start=1, op=MTHI, write srcA to HI at that edge; op=MTLO writes LO; busy stays 0.
REQ-019 SHALL treat op codes 3'b110/3'b111 as no-op: no state change, busy stays 0.
REQ-020 SHALL compute MULT as signed 32x32->64, MULTU unsigned; HI = product[63:32], LO = product[31:0].
REQ-021 SHALL compute DIV signed: LO = quotient truncated toward zero, HI = remainder with sign of dividend.
REQ-022 SHALL compute DIVU unsigned: LO = quotient, HI = remainder.
REQ-023 SHALL on divide with srcB=0 still go BUSY for DIV_CYCLES but leave HI/LO unchanged at completion.
REQ-024 SHALL on DIV with srcA=0x80000000, srcB=0xFFFFFFFF produce LO=0x80000000, HI=0x00000000.
REQ-025 SHALL sample srcA/srcB only at accepting edge; operand changes during BUSY have no effect.
REQ-026 SHALL permit start in the cycle busy first reads 0 (back-to-back ops, no dead cycle).

Reset
REQ-027 SHALL on reset=0, immediately (no clock) force state IDLE, busy=0, HI=0, LO=0, cnt=0, hi_n/lo_n=0.
REQ-028 SHALL abort any in-flight op on reset mid-BUSY; no result committed after release.
REQ-029 SHALL ignore start while reset=0; first accepted start is at the first rising edge with reset=1.

Verification
REQ-030 SHALL cover MULT srcA=0xFFFFFFFE(-2), srcB=3 -> busy high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA; MULTU same operands -> HI=0x00000002, LO=0xFFFFFFFA.
REQ-031 SHALL cover DIV srcA=0xFFFFFFF9(-7), srcB=2 -> busy 10 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7/2 -> LO=3, HI=1.
REQ-032 SHALL cover DIVU srcB=0 with HI=0x11, LO=0x22 preset via MTHI/MTLO -> busy 10 cycles, HI=0x11, LO=0x22 after.
REQ-033 SHALL cover MTLO 0xABCD issued during MULT busy -> ignored; LO equals multiply result after busy falls.
REQ-034 SHALL cover reset=0 asserted at BUSY cycle 3 of DIV -> busy=0, HI=LO=0 immediately, stay 0 after release.
REQ-035 SHALL cover back-to-back MULT then DIV with start in first non-busy cycle -> second op accepted, busy low for 1 cycle between (the commit cycle) or 0 gap per REQ-026, both results correct.
